// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time program image loader for instruction memory
//
// Purpose:
//   Receives a framed program image as a byte stream and writes it into
//   instruction memory as big-endian 32-bit words from word address 0.
//   Frame: LEN_HI, LEN_LO (word count N), N*4 data bytes, CSUM byte.
//   CSUM is the XOR of the data bytes. On success the processor is released
//   (o_cpu_start_up drops). On a length or checksum error it stays held and
//   o_load_err is raised. DONE and ERROR are terminal until i_start_up.
//
// Ports:
//   i_clk           system clock, all logic on posedge
//   i_start_up      synchronous active-high reset, also restarts a load
//   i_rx_valid      i_rx_data holds a valid byte
//   i_rx_data       stream byte
//   o_rx_ready      loader accepts a byte this cycle (combinational)
//   o_imem_we       instruction memory write strobe, one cycle per word
//   o_imem_addr     word address for the write
//   o_imem_wdata    word to write
//   o_cpu_start_up  processor start_up; high until the image is verified
//   o_load_done     image loaded and checksum matched (sticky)
//   o_load_err      length or checksum error (sticky)
//   o_words_loaded  count of words written during this load

module program_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              i_clk,
  input  logic              i_start_up,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_start_up,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [15:0]   DEPTH_16 = 16'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_next;

  logic [7:0]        r_len_hi;
  // Word count is range-checked against IMEM_DEPTH before it is stored,
  // so ADDR_W+1 bits are enough to hold it.
  logic [ADDR_W:0]   r_nwords;
  logic [ADDR_W:0]   r_word_cnt;
  logic [1:0]        r_byte_sel;
  logic [23:0]       r_shift;
  logic [7:0]        r_csum;

  logic              w_accept;
  logic [15:0]       w_len;
  logic              w_word_done;
  logic              w_last_word;

  assign o_rx_ready = !i_start_up &&
                      ((r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                       (r_state == ST_DATA)   || (r_state == ST_CSUM));

  assign w_accept    = i_rx_valid && o_rx_ready;
  assign w_len       = {r_len_hi, i_rx_data};
  assign w_word_done = (r_byte_sel == 2'd3);
  assign w_last_word = ((r_word_cnt + CNT_ONE) == r_nwords);

  // Words written so far is exactly the write counter, which advances on the
  // same edge that raises o_imem_we.
  assign o_words_loaded = r_word_cnt;

  always_ff @(posedge i_clk) begin
    if (i_start_up) begin
      r_state <= ST_LEN_HI;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LEN_HI: begin
        if (w_accept) begin
          w_state_next = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          if (w_len > DEPTH_16) begin
            w_state_next = ST_ERROR;
          end else if (w_len == 16'd0) begin
            w_state_next = ST_CSUM;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept && w_word_done && w_last_word) begin
          w_state_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_state_next = (i_rx_data == r_csum) ? ST_DONE : ST_ERROR;
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_start_up) begin
      r_len_hi       <= 8'h00;
      r_nwords       <= '0;
      r_word_cnt     <= '0;
      r_byte_sel     <= 2'd0;
      r_shift        <= 24'h0;
      r_csum         <= 8'h00;
      o_imem_we      <= 1'b0;
      o_imem_addr    <= '0;
      o_imem_wdata   <= 32'h0;
      o_cpu_start_up <= 1'b1;
      o_load_done    <= 1'b0;
      o_load_err     <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;

      if (w_accept) begin
        case (r_state)
          ST_LEN_HI: r_len_hi <= i_rx_data;
          ST_LEN_LO: r_nwords <= w_len[ADDR_W:0];
          ST_DATA: begin
            r_csum     <= r_csum ^ i_rx_data;
            r_byte_sel <= r_byte_sel + 2'd1;
            if (w_word_done) begin
              // Fourth byte completes the word: the write goes out on the
              // next cycle while the following byte is already being taken.
              o_imem_we    <= 1'b1;
              o_imem_addr  <= r_word_cnt[ADDR_W-1:0];
              o_imem_wdata <= {r_shift, i_rx_data};
              r_word_cnt   <= r_word_cnt + CNT_ONE;
            end else begin
              r_shift <= {r_shift[15:0], i_rx_data};
            end
          end
          default: begin
          end
        endcase
      end

      // Terminal states never leave, so re-applying these while parked
      // leaves the flags unchanged.
      if (w_state_next == ST_DONE) begin
        o_cpu_start_up <= 1'b0;
        o_load_done    <= 1'b1;
      end
      if (w_state_next == ST_ERROR) begin
        o_cpu_start_up <= 1'b1;
        o_load_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader

module tb_program_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          start_up;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_start_up;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  program_loader #(
    .IMEM_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .i_clk         (clk),
    .i_start_up    (start_up),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_rx_ready    (rx_ready),
    .o_imem_we     (imem_we),
    .o_imem_addr   (imem_addr),
    .o_imem_wdata  (imem_wdata),
    .o_cpu_start_up(cpu_start_up),
    .o_load_done   (load_done),
    .o_load_err    (load_err),
    .o_words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;

  wr_t         exp_q[$];
  int          acc_count;
  int          stop_count;
  int          we_count;
  bit          exp_ok;
  bit          prev_we;
  logic [31:0] mem [0:DEPTH-1];
  int          last_we_addr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: derive the expected writes, where the frame ends and
  // the outcome straight from the frame bytes.
  function automatic void set_frame(input logic [7:0] f[$]);
    int          n;
    logic [7:0]  cs;
    exp_q.delete();
    n = (int'(f[0]) << 8) | int'(f[1]);
    if (n > DEPTH) begin
      stop_count = 2;
      exp_ok     = 1'b0;
    end else begin
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
        wr_t w;
        w.addr = AW'(i);
        w.data = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
        exp_q.push_back(w);
        cs = cs ^ f[2+4*i] ^ f[3+4*i] ^ f[4+4*i] ^ f[5+4*i];
      end
      stop_count = 3 + 4 * n;
      exp_ok     = (f[2+4*n] == cs);
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (start_up) begin
      chk("ready_in_reset", 32'(rx_ready), 32'd0);
      acc_count  = 0;
      we_count   = 0;
      stop_count = 1 << 30;
      exp_ok     = 1'b0;
      prev_we    = 1'b0;
      exp_q.delete();
    end else begin
      if (imem_we) begin
        chk("we_single_cycle", 32'(prev_we), 32'd0);
        we_count++;
        chk("we_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          wr_t w;
          w = exp_q.pop_front();
          chk("imem_addr", 32'(imem_addr), 32'(w.addr));
          chk("imem_wdata", imem_wdata, w.data);
        end
        mem[imem_addr] = imem_wdata;
        last_we_addr   = int'(imem_addr);
      end
      prev_we = imem_we;
      chk("words_loaded", 32'(words_loaded), 32'(we_count));
      chk("rx_ready", 32'(rx_ready), 32'(acc_count < stop_count));
      if (acc_count < stop_count) begin
        chk("cpu_start_up", 32'(cpu_start_up), 32'd1);
        chk("load_done", 32'(load_done), 32'd0);
        chk("load_err", 32'(load_err), 32'd0);
      end else begin
        chk("cpu_start_up", 32'(cpu_start_up), 32'(!exp_ok));
        chk("load_done", 32'(load_done), 32'(exp_ok));
        chk("load_err", 32'(load_err), 32'(!exp_ok));
      end
      if (rx_valid && rx_ready) acc_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    start_up = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    start_up = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t        = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_accepted", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int gap, input int count);
    int lim;
    lim = (count < 0) ? f.size() : count;
    for (int i = 0; i < lim; i++) begin
      send_byte(f[i]);
      idle(gap);
    end
  endtask

  task automatic push_ignored(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    idle(3);
    rx_valid = 1'b0;
  endtask

  task automatic check_test1_result(input string tag);
    chk({tag, "_mem0"}, mem[0], 32'h20080005);
    chk({tag, "_mem1"}, mem[1], 32'hAC010004);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_cpu"}, 32'(cpu_start_up), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd2);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] t1[$];
  logic [7:0] tf[$];
  logic [7:0] cs;
  logic [31:0] w;

  initial begin
    start_up = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    start_up = 1'b0;

    @(negedge clk);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_cpu", 32'(cpu_start_up), 32'd1);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;

    // Two-word image with correct checksum
    t1 = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04, 8'h84};
    set_frame(t1);
    send_frame(t1, 0, -1);
    idle(2);
    check_test1_result("t1");

    // Wrong checksum; trailing bytes ignored
    do_reset();
    tf = t1;
    tf[10] = 8'h85;
    set_frame(tf);
    send_frame(tf, 0, -1);
    push_ignored(8'h55);
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_cpu", 32'(cpu_start_up), 32'd1);
    chk("t2_done", 32'(load_done), 32'd0);
    chk("t2_ready", 32'(rx_ready), 32'd0);

    // Length one beyond capacity
    do_reset();
    tf = {8'h04, 8'h01};
    set_frame(tf);
    send_frame(tf, 0, -1);
    push_ignored(8'h20);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_no_writes", 32'(we_count), 32'd0);

    // Empty image: good and bad checksum
    do_reset();
    tf = {8'h00, 8'h00, 8'h00};
    set_frame(tf);
    send_frame(tf, 0, -1);
    idle(1);
    chk("t4a_done", 32'(load_done), 32'd1);
    chk("t4a_words", 32'(words_loaded), 32'd0);
    do_reset();
    tf = {8'h00, 8'h00, 8'h01};
    set_frame(tf);
    send_frame(tf, 0, -1);
    idle(1);
    chk("t4b_err", 32'(load_err), 32'd1);

    // Same image with a gap after every byte
    do_reset();
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    set_frame(t1);
    send_frame(t1, 1, -1);
    idle(2);
    check_test1_result("t5");

    // Abort mid-load, then a full reload
    do_reset();
    set_frame(t1);
    send_frame(t1, 0, 7);
    do_reset();
    @(negedge clk);
    chk("t6_rst_addr", 32'(imem_addr), 32'd0);
    chk("t6_rst_wdata", imem_wdata, 32'd0);
    chk("t6_rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1;
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    set_frame(t1);
    send_frame(t1, 0, -1);
    idle(2);
    check_test1_result("t6");

    // Full-capacity image
    do_reset();
    tf = {8'h04, 8'h00};
    cs = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'hA5000000 ^ (i * 32'h00010003);
      tf.push_back(w[31:24]);
      tf.push_back(w[23:16]);
      tf.push_back(w[15:8]);
      tf.push_back(w[7:0]);
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    tf.push_back(cs);
    set_frame(tf);
    send_frame(tf, 0, -1);
    idle(2);
    chk("t6max_last_addr", 32'(last_we_addr), 32'd1023);
    chk("t6max_last_word", mem[1023], 32'hA6FF0BFD);
    chk("t6max_words", 32'(words_loaded), 32'd1024);
    chk("t6max_done", 32'(load_done), 32'd1);
    chk("t6max_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
